// File: rtl/round_robin_selector.sv
// rtl/round_robin_selector.sv - round-robin arbiter driving the select lines of a 4:1 mux
//
// Purpose
//   Picks one of four requesters in round-robin order and drives the 4:1
//   multiplexer address lines directly from flops. A grant is held until the
//   grantee signals done, drops its request, or (optionally) exceeds its
//   hold budget.
//
// Ports
//   clk          in   1  clock, rising edge
//   rst_n        in   1  synchronous active-low reset
//   req          in   4  per-source request, bit i selects mux input in_i
//   done         in   1  current grantee releases at the end of this cycle
//   address0     out  1  mux select LSB
//   address1     out  1  mux select MSB
//   grant        out  4  one-hot grant, 0 when grant_valid=0
//   grant_valid  out  1  mux output owned by a source
//   timeout      out  1  one-cycle pulse on forced release
//
// Parameters
//   HOLD_MAX     maximum consecutive grant cycles before forced release (1..255)
//
// Build option
//   SELECTOR_TIMEOUT_EN  when defined, enables forced release after HOLD_MAX
//                        cycles; when undefined, timeout stays 0.

module round_robin_selector #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic       address0,
    output logic       address1,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic       timeout
);

`ifdef SELECTOR_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] hold_cnt;

    logic [1:0] addr;
    logic       forced;
    logic       release_evt;
    logic [3:0] cand;
    logic       found;
    logic [1:0] winner;

    always_comb begin
        addr   = {address1, address0};
        forced = TIMEOUT_EN && (state == GRANT) && (hold_cnt == HOLD_LIMIT);
        release_evt = done || !req[addr] || forced;

        // The current grantee is excluded from the search when it gave up the
        // bus voluntarily or was forced off; ptr already ranks it last.
        if (state == GRANT && (done || forced))
            cand = req & ~grant;
        else
            cand = req;

        // Descending scan so the final hit is the lowest offset from ptr.
        found  = 1'b0;
        winner = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (cand[ptr + 2'(i)]) begin
                found  = 1'b1;
                winner = ptr + 2'(i);
            end
        end

        // Sole remaining requester after a done release is re-granted.
        if (state == GRANT && !found && done && req[addr]) begin
            found  = 1'b1;
            winner = addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            address0    <= 1'b0;
            address1    <= 1'b0;
            grant       <= 4'b0000;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            ptr         <= 2'd0;
            hold_cnt    <= 8'd0;
        end else begin
            timeout <= 1'b0;
            if (state == IDLE || release_evt) begin
                if (state == GRANT)
                    timeout <= forced;
                if (found) begin
                    state       <= GRANT;
                    address0    <= winner[0];
                    address1    <= winner[1];
                    grant       <= 4'b0001 << winner;
                    grant_valid <= 1'b1;
                    ptr         <= winner + 2'd1;
                    hold_cnt    <= 8'd0;
                end else begin
                    state       <= IDLE;
                    grant       <= 4'b0000;
                    grant_valid <= 1'b0;
                end
            end else if (hold_cnt != 8'hFF) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_round_robin_selector.sv
// tb/tb_round_robin_selector.sv - directed self-checking bench for round_robin_selector

module tb_round_robin_selector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       address0;
    logic       address1;
    logic [3:0] grant;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    round_robin_selector #(.HOLD_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .address0    (address0),
        .address1    (address1),
        .grant       (grant),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed view: {address1, address0, grant_valid, timeout, grant}
    task automatic chk(input string tag, input logic [1:0] a, input logic v,
                       input logic t, input logic [3:0] g);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {address1, address0, grant_valid, timeout, grant};
        exp = {a, v, t, g};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        step();
        step();
        chk("reset", 2'b00, 1'b0, 1'b0, 4'b0000);

        // Single request from source 2, then drop it
        rst_n = 1'b1;
        req   = 4'b0100;
        step();
        chk("first_grant_src2", 2'b10, 1'b1, 1'b0, 4'b0100);
        req = 4'b0000;
        step();
        chk("drop_to_idle_addr_held", 2'b10, 1'b0, 1'b0, 4'b0000);
        step();
        chk("idle_stays", 2'b10, 1'b0, 1'b0, 4'b0000);

        // Full rotation with done every cycle
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req   = 4'b1111;
        step();
        chk("rot_0", 2'b00, 1'b1, 1'b0, 4'b0001);
        done = 1'b1;
        step();
        chk("rot_1", 2'b01, 1'b1, 1'b0, 4'b0010);
        step();
        chk("rot_2", 2'b10, 1'b1, 1'b0, 4'b0100);
        step();
        chk("rot_3", 2'b11, 1'b1, 1'b0, 4'b1000);
        step();
        chk("rot_wrap", 2'b00, 1'b1, 1'b0, 4'b0001);

        // Sole requester re-granted after done
        req = 4'b0001;
        step();
        chk("regrant_sole", 2'b00, 1'b1, 1'b0, 4'b0001);
        done = 1'b0;
        req  = 4'b0011;
        step();
        chk("hold_no_release", 2'b00, 1'b1, 1'b0, 4'b0001);
        req = 4'b0010;
        step();
        chk("req_drop_switch", 2'b01, 1'b1, 1'b0, 4'b0010);

        // Hold-limit behaviour, HOLD_MAX=4
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req   = 4'b0011;
        step();
        chk("hold_c1", 2'b00, 1'b1, 1'b0, 4'b0001);
        step();
        chk("hold_c2", 2'b00, 1'b1, 1'b0, 4'b0001);
        step();
        chk("hold_c3", 2'b00, 1'b1, 1'b0, 4'b0001);
        step();
        chk("hold_c4", 2'b00, 1'b1, 1'b0, 4'b0001);
        step();
`ifdef SELECTOR_TIMEOUT_EN
        chk("forced_release", 2'b01, 1'b1, 1'b1, 4'b0010);
        step();
        chk("timeout_one_cycle", 2'b01, 1'b1, 1'b0, 4'b0010);
`else
        chk("no_forced_release", 2'b00, 1'b1, 1'b0, 4'b0001);
        step();
        chk("still_held", 2'b00, 1'b1, 1'b0, 4'b0001);
`endif

        // Reset during a grant of source 3
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req   = 4'b1000;
        step();
        chk("grant_src3", 2'b11, 1'b1, 1'b0, 4'b1000);
        rst_n = 1'b0;
        step();
        chk("reset_mid_grant", 2'b00, 1'b0, 1'b0, 4'b0000);
        rst_n = 1'b1;
        req   = 4'b1001;
        step();
        chk("after_reset_src0", 2'b00, 1'b1, 1'b0, 4'b0001);

        // Reset must also clear ptr: grant source 2 (ptr=3), reset, then 1001
        req = 4'b0100;
        done = 1'b1;
        step();
        chk("grant_src2_again", 2'b10, 1'b1, 1'b0, 4'b0100);
        done  = 1'b0;
        rst_n = 1'b0;
        step();
        chk("reset_mid_grant2", 2'b00, 1'b0, 1'b0, 4'b0000);
        rst_n = 1'b1;
        req   = 4'b1001;
        step();
        chk("ptr_cleared_src0", 2'b00, 1'b1, 1'b0, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
